fifo_drain_scheduler: RTL and testbench

Round-robin read scheduler that drains the five systolic-array output FIFOs into the result memory. On `init` it issues one-hot FIFO reads, skipping empty or finished lanes, and pipelines each word to a memory write at `base_address + count*ROW + lane`. When every lane has delivered `DEPTH` words it pulses `com`. It sits between the FIFO bank and the result memory, replacing fixed-order mux sequencing with empty-aware arbitration.

---
 rtl/fifo_drain_scheduler.sv | 225 ++++++++++++++++++++++
 tb/tb_fifo_drain_scheduler.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_scheduler.sv
// fifo_drain_scheduler: round-robin, empty-aware drain of five systolic-array
// output FIFOs into the result memory. Each granted read becomes a memory write
// two cycles later at base + count*ROW + lane. A one-cycle com pulse marks the
// point where every lane has delivered DEPTH words.
module fifo_drain_scheduler #(
  parameter int unsigned N     = 32,
  parameter int unsigned ROW   = 5,
  parameter int unsigned DEPTH = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         init,
  input  logic [7:0]   base_address,
  input  logic [4:0]   buf_empty,
  input  logic [N-1:0] in0,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic [N-1:0] in3,
  input  logic [N-1:0] in4,
  output logic [4:0]   rd_en,
  output logic         mem_we,
  output logic [7:0]   mem_addr,
  output logic [N-1:0] mem_data,
  output logic         busy,
  output logic         com
);

  localparam int Lanes = 5;
  localparam logic [5:0] DepthW = 6'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e state_q, state_d;

  // Job context
  logic [7:0] base_q;
  logic [5:0] cnt_q [Lanes];
  logic [2:0] ptr_q;

  // Stage 1: read issued, FIFO data appears on in<lane> during this stage
  logic       v1_q;
  logic [2:0] lane1_q;
  logic [7:0] addr1_q;

  // Arbitration results
  logic [Lanes-1:0] eligible;
  logic [7:0]       elig_pad;
  logic [3:0]       idx;
  logic             grant_vld;
  logic [2:0]       grant_lane;
  logic             grant;
  logic [5:0]       cnt_g;
  logic [31:0]      addr_full;
  logic [7:0]       grant_addr;
  logic             all_done_next;
  logic [5:0]       cnt_after;
  logic [N-1:0]     in_sel;

  // Lane eligibility: data present and quota not yet reached
  always_comb begin
    eligible = '0;
    for (int l = 0; l < Lanes; l++) begin
      eligible[l] = !buf_empty[l] && (cnt_q[l] < DepthW);
    end
    elig_pad = {3'b000, eligible};
  end

  // Round-robin search starting at ptr, first eligible lane wins
  always_comb begin
    grant_vld  = 1'b0;
    grant_lane = 3'd0;
    idx        = 4'd0;
    for (int k = 0; k < Lanes; k++) begin
      idx = {1'b0, ptr_q} + 4'(k);
      if (idx >= 4'd5) begin
        idx = idx - 4'd5;
      end
      if (!grant_vld && elig_pad[idx[2:0]]) begin
        grant_vld  = 1'b1;
        grant_lane = idx[2:0];
      end
    end
  end

  // Grant qualification, read enable and write address for the granted lane
  always_comb begin
    grant = grant_vld && (state_q == StRun);
    cnt_g = 6'd0;
    for (int l = 0; l < Lanes; l++) begin
      if (grant_lane == 3'(l)) begin
        cnt_g = cnt_q[l];
      end
    end
    // Address uses the pre-increment count; wraps modulo 256 by design
    addr_full  = 32'(cnt_g) * ROW + 32'(grant_lane) + 32'(base_q);
    grant_addr = addr_full[7:0];
    if (grant && !rst) begin
      rd_en = 5'd1 << grant_lane;
    end else begin
      rd_en = 5'd0;
    end
  end

  // Detect that the current edge completes the final lane quota
  always_comb begin
    all_done_next = 1'b1;
    cnt_after     = 6'd0;
    for (int l = 0; l < Lanes; l++) begin
      cnt_after = cnt_q[l];
      if (grant && (grant_lane == 3'(l))) begin
        cnt_after = cnt_q[l] + 6'd1;
      end
      if (cnt_after != DepthW) begin
        all_done_next = 1'b0;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (init) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (all_done_next) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Wait for the pipeline to empty so com follows the final write
        if (!v1_q && !mem_we) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != StIdle);
    com  = (state_q == StDone);
  end

  // Job context and stage-1 pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q  <= 8'd0;
      ptr_q   <= 3'd0;
      v1_q    <= 1'b0;
      lane1_q <= 3'd0;
      addr1_q <= 8'd0;
      for (int l = 0; l < Lanes; l++) begin
        cnt_q[l] <= 6'd0;
      end
    end else begin
      if ((state_q == StIdle) && init) begin
        base_q <= base_address;
        ptr_q  <= 3'd0;
        for (int l = 0; l < Lanes; l++) begin
          cnt_q[l] <= 6'd0;
        end
      end else if (grant) begin
        ptr_q <= (grant_lane == 3'd4) ? 3'd0 : grant_lane + 3'd1;
        for (int l = 0; l < Lanes; l++) begin
          if (grant_lane == 3'(l)) begin
            cnt_q[l] <= cnt_q[l] + 6'd1;
          end
        end
      end
      v1_q <= grant;
      if (grant) begin
        lane1_q <= grant_lane;
        addr1_q <= grant_addr;
      end
    end
  end

  // Stage-2 data select by the lane that was read one cycle earlier
  always_comb begin
    in_sel = in0;
    unique case (lane1_q)
      3'd0:    in_sel = in0;
      3'd1:    in_sel = in1;
      3'd2:    in_sel = in2;
      3'd3:    in_sel = in3;
      3'd4:    in_sel = in4;
      default: in_sel = in0;
    endcase
  end

  // Stage-2 memory write registers; address/data hold between writes
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we   <= 1'b0;
      mem_addr <= 8'd0;
      mem_data <= '0;
    end else begin
      mem_we <= v1_q;
      if (v1_q) begin
        mem_addr <= addr1_q;
        mem_data <= in_sel;
      end
    end
  end

endmodule

// File: tb/tb_fifo_drain_scheduler.sv
// Directed bench for fifo_drain_scheduler with DEPTH=2, backed by a simple
// five-lane FIFO model and a negedge write/read/com monitor.
module tb_fifo_drain_scheduler;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         init;
  logic [7:0]   base_address;
  logic [4:0]   buf_empty;
  logic [N-1:0] in_r [5];
  logic [4:0]   rd_en;
  logic         mem_we;
  logic [7:0]   mem_addr;
  logic [N-1:0] mem_data;
  logic         busy;
  logic         com;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fifo_drain_scheduler #(
    .N    (32),
    .ROW  (5),
    .DEPTH(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .init        (init),
    .base_address(base_address),
    .buf_empty   (buf_empty),
    .in0         (in_r[0]),
    .in1         (in_r[1]),
    .in2         (in_r[2]),
    .in3         (in_r[3]),
    .in4         (in_r[4]),
    .rd_en       (rd_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .busy        (busy),
    .com         (com)
  );

  // FIFO model: tasks push (wp), the clocked process pops (rp)
  logic [N-1:0] fmem [5][16];
  int wp [5];
  int rp [5];

  always_comb begin
    buf_empty = '0;
    for (int l = 0; l < 5; l++) begin
      buf_empty[l] = (wp[l] == rp[l]);
    end
  end

  always @(posedge clk) begin
    for (int l = 0; l < 5; l++) begin
      if (rd_en[l]) begin
        in_r[l] <= fmem[l][rp[l] & 15];
        rp[l]   <= rp[l] + 1;
      end
    end
  end

  // Monitor logs
  logic [7:0]   wa [$];
  logic [N-1:0] wd [$];
  logic [4:0]   rq [$];
  int com_cnt   = 0;
  int wr_at_com = 0;

  always @(negedge clk) begin
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_data);
    end
    if (rd_en != 5'd0) rq.push_back(rd_en);
    if (com) begin
      com_cnt   = com_cnt + 1;
      wr_at_com = wa.size();
    end
  end

  function automatic logic [N-1:0] mk(input int l, input int k);
    return 32'hA500_0000 | 32'(l << 8) | 32'(k);
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int l, input logic [N-1:0] w);
    fmem[l][wp[l] & 15] = w;
    wp[l] = wp[l] + 1;
  endtask

  task automatic preload_all();
    for (int l = 0; l < 5; l++) begin
      for (int k = 0; k < 2; k++) push(l, mk(l, k));
    end
  endtask

  task automatic flush();
    for (int l = 0; l < 5; l++) wp[l] = rp[l];
  endtask

  task automatic start_job(input logic [7:0] b);
    init = 1'b1;
    base_address = b;
    step();
    init = 1'b0;
  endtask

  task automatic wait_com(input int budget, output bit ok);
    int c0;
    int i;
    c0 = com_cnt;
    i = 0;
    while (com_cnt == c0 && i < budget) begin
      step();
      i++;
    end
    ok = (com_cnt != c0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    init = 1'b0;
    base_address = 8'h00;
    for (int l = 0; l < 5; l++) begin
      wp[l] = 0;
      rp[l] = 0;
    end
    step();
    step();
    rst = 1'b0;
    step();
    n_total++;
    if ({rd_en, mem_we, busy, com} !== 8'd0) begin
      $display("FAIL reset_ctrl: got rd_en=%b we=%b busy=%b com=%b required all 0",
               rd_en, mem_we, busy, com);
    end else n_pass++;
    n_total++;
    if (mem_addr !== 8'd0 || mem_data !== '0) begin
      $display("FAIL reset_data: got addr=%h data=%h required 0", mem_addr, mem_data);
    end else n_pass++;
  endtask

  task automatic test_basic();
    int w0, r0, c0;
    bit ok;
    preload_all();
    step();
    n_total++;
    if (rd_en !== 5'd0) $display("FAIL idle_rd_en: got %b required 00000", rd_en);
    else n_pass++;
    w0 = wa.size();
    r0 = rq.size();
    c0 = com_cnt;
    start_job(8'h10);
    n_total++;
    if (busy !== 1'b1 || rd_en !== 5'b00001) begin
      $display("FAIL start: got busy=%b rd_en=%b required 1 00001", busy, rd_en);
    end else n_pass++;
    step();
    n_total++;
    if (mem_we !== 1'b0) $display("FAIL latency_early: got mem_we=%b required 0", mem_we);
    else n_pass++;
    step();
    n_total++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h10 || mem_data !== mk(0, 0)) begin
      $display("FAIL first_write: got we=%b addr=%h data=%h required 1 10 %h",
               mem_we, mem_addr, mem_data, mk(0, 0));
    end else n_pass++;
    wait_com(60, ok);
    n_total++;
    if (!ok) $display("FAIL basic_com: got no com required com within 60 cycles");
    else n_pass++;
    n_total++;
    if (busy !== 1'b1 || com !== 1'b1) begin
      $display("FAIL done_cycle: got busy=%b com=%b required 1 1", busy, com);
    end else n_pass++;
    n_total++;
    if (wa.size() - w0 != 10 || com_cnt - c0 != 1 || wr_at_com != w0 + 10) begin
      $display("FAIL basic_counts: got writes=%0d coms=%0d at_com=%0d required 10 1 %0d",
               wa.size() - w0, com_cnt - c0, wr_at_com, w0 + 10);
    end else n_pass++;
    if (wa.size() - w0 == 10 && rq.size() - r0 == 10) begin
      for (int i = 0; i < 10; i++) begin
        n_total++;
        if (rq[r0 + i] !== 5'(1 << (i % 5)) || wa[w0 + i] !== 8'(8'h10 + i) ||
            wd[w0 + i] !== mk(i % 5, i / 5)) begin
          $display("FAIL basic_seq[%0d]: got rd=%b addr=%h data=%h required %b %h %h", i,
                   rq[r0 + i], wa[w0 + i], wd[w0 + i], 5'(1 << (i % 5)), 8'(8'h10 + i),
                   mk(i % 5, i / 5));
        end else n_pass++;
      end
    end
    step();
    n_total++;
    if (busy !== 1'b0 || com !== 1'b0) begin
      $display("FAIL post_done: got busy=%b com=%b required 0 0", busy, com);
    end else n_pass++;
  endtask

  task automatic test_lane2_late();
    int w0, c0;
    bit ok;
    logic [7:0] exp_a [10];
    exp_a = '{8'h10, 8'h11, 8'h13, 8'h14, 8'h15, 8'h16, 8'h18, 8'h19, 8'h12, 8'h17};
    for (int l = 0; l < 5; l++) begin
      if (l != 2) begin
        for (int k = 0; k < 2; k++) push(l, mk(l, k));
      end
    end
    w0 = wa.size();
    c0 = com_cnt;
    start_job(8'h10);
    for (int i = 0; i < 10; i++) step();
    n_total++;
    if (rd_en !== 5'd0 || busy !== 1'b1 || com_cnt != c0) begin
      $display("FAIL lane2_stall: got rd_en=%b busy=%b coms=%0d required 00000 1 0",
               rd_en, busy, com_cnt - c0);
    end else n_pass++;
    push(2, mk(2, 0));
    push(2, mk(2, 1));
    wait_com(40, ok);
    n_total++;
    if (!ok || wr_at_com != w0 + 10 || com_cnt - c0 != 1) begin
      $display("FAIL lane2_com: got ok=%0d writes_at_com=%0d coms=%0d required 1 10 1",
               ok, wr_at_com - w0, com_cnt - c0);
    end else n_pass++;
    if (wa.size() - w0 == 10) begin
      for (int i = 0; i < 10; i++) begin
        int off;
        off = int'(exp_a[i]) - 16;
        n_total++;
        if (wa[w0 + i] !== exp_a[i] || wd[w0 + i] !== mk(off % 5, off / 5)) begin
          $display("FAIL lane2_seq[%0d]: got addr=%h data=%h required %h %h", i,
                   wa[w0 + i], wd[w0 + i], exp_a[i], mk(off % 5, off / 5));
        end else n_pass++;
      end
    end
    step();
  endtask

  task automatic test_all_empty();
    int w0, c0;
    w0 = wa.size();
    c0 = com_cnt;
    start_job(8'h40);
    for (int i = 0; i < 20; i++) begin
      n_total++;
      if (busy !== 1'b1 || rd_en !== 5'd0 || mem_we !== 1'b0 || com !== 1'b0) begin
        $display("FAIL empty_hold[%0d]: got busy=%b rd_en=%b we=%b com=%b required 1 0 0 0",
                 i, busy, rd_en, mem_we, com);
      end else n_pass++;
      step();
    end
    n_total++;
    if (wa.size() != w0 || com_cnt != c0) begin
      $display("FAIL empty_none: got writes=%0d coms=%0d required 0 0",
               wa.size() - w0, com_cnt - c0);
    end else n_pass++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_total++;
    if (busy !== 1'b0) $display("FAIL empty_abort: got busy=%b required 0", busy);
    else n_pass++;
  endtask

  task automatic test_init_during_run();
    int w0;
    bit ok;
    preload_all();
    w0 = wa.size();
    start_job(8'h20);
    step();
    step();
    init = 1'b1;
    base_address = 8'h80;
    step();
    init = 1'b0;
    wait_com(60, ok);
    n_total++;
    if (!ok || wa.size() - w0 != 10) begin
      $display("FAIL reinit_count: got ok=%0d writes=%0d required 1 10", ok, wa.size() - w0);
    end else n_pass++;
    if (wa.size() - w0 == 10) begin
      for (int i = 0; i < 10; i++) begin
        n_total++;
        if (wa[w0 + i] !== 8'(8'h20 + i) || wd[w0 + i] !== mk(i % 5, i / 5)) begin
          $display("FAIL reinit_seq[%0d]: got addr=%h data=%h required %h %h", i,
                   wa[w0 + i], wd[w0 + i], 8'(8'h20 + i), mk(i % 5, i / 5));
        end else n_pass++;
      end
    end
    step();
  endtask

  task automatic test_wrap();
    int w0;
    bit ok;
    logic [7:0] ea;
    preload_all();
    w0 = wa.size();
    start_job(8'hFE);
    wait_com(60, ok);
    n_total++;
    if (!ok || wa.size() - w0 != 10) begin
      $display("FAIL wrap_count: got ok=%0d writes=%0d required 1 10", ok, wa.size() - w0);
    end else n_pass++;
    if (wa.size() - w0 == 10) begin
      // lane 2 count 0 lands on 0x00, lane 4 count 1 on 0x07
      for (int i = 0; i < 10; i++) begin
        ea = 8'hFE + 8'(i);
        n_total++;
        if (wa[w0 + i] !== ea) begin
          $display("FAIL wrap_addr[%0d]: got %h required %h", i, wa[w0 + i], ea);
        end else n_pass++;
      end
    end
    step();
  endtask

  task automatic test_rst_mid();
    int w1, c1, w0, i;
    bit ok;
    preload_all();
    start_job(8'h30);
    i = 0;
    while (mem_we !== 1'b1 && i < 10) begin
      step();
      i++;
    end
    n_total++;
    if (mem_we !== 1'b1) $display("FAIL rst_first_write: got mem_we=%b required 1", mem_we);
    else n_pass++;
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    n_total++;
    if (rd_en !== 5'd0) $display("FAIL rst_rd_en: got %b required 00000", rd_en);
    else n_pass++;
    step();
    rst = 1'b0;
    #1;
    n_total++;
    if ({rd_en, mem_we, busy, com} !== 8'd0 || mem_addr !== 8'd0 || mem_data !== '0) begin
      $display("FAIL rst_outputs: got rd=%b we=%b busy=%b com=%b addr=%h data=%h required 0",
               rd_en, mem_we, busy, com, mem_addr, mem_data);
    end else n_pass++;
    w1 = wa.size();
    c1 = com_cnt;
    for (int k = 0; k < 10; k++) step();
    n_total++;
    if (wa.size() != w1 || com_cnt != c1) begin
      $display("FAIL rst_quiet: got writes=%0d coms=%0d required 0 0",
               wa.size() - w1, com_cnt - c1);
    end else n_pass++;
    flush();
    preload_all();
    w0 = wa.size();
    start_job(8'h30);
    n_total++;
    if (rd_en !== 5'b00001) $display("FAIL restart_ptr: got %b required 00001", rd_en);
    else n_pass++;
    wait_com(60, ok);
    n_total++;
    if (!ok || wa.size() - w0 != 10) begin
      $display("FAIL restart_count: got ok=%0d writes=%0d required 1 10", ok, wa.size() - w0);
    end else n_pass++;
    if (wa.size() - w0 == 10) begin
      for (int k = 0; k < 10; k++) begin
        n_total++;
        if (wa[w0 + k] !== 8'(8'h30 + k) || wd[w0 + k] !== mk(k % 5, k / 5)) begin
          $display("FAIL restart_seq[%0d]: got addr=%h data=%h required %h %h", k,
                   wa[w0 + k], wd[w0 + k], 8'(8'h30 + k), mk(k % 5, k / 5));
        end else n_pass++;
      end
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_lane2_late();
    test_all_empty();
    test_init_during_run();
    test_wrap();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
